fft_frame_scheduler: RTL and testbench

FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

---
 rtl/fft_sched_pkg.sv | 15 +
 rtl/frame_bank_ram.sv | 23 ++
 rtl/fft_frame_scheduler.sv | 165 ++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and defaults for the FFT frame scheduler.
// State encoding of the read FSM plus default geometry and FFT beat width.
package fft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } rd_state_t;

  localparam int DEF_FRAME_LEN = 1024;
  localparam int DEF_SAMPLE_W  = 8;
  localparam int BEAT_W        = 16;

endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port, registered read port.
// Read latency 1 cycle; no backpressure, contents are not reset.
module frame_bank_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_m,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_m) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame buffer feeding an FFT core: fills one bank while streaming the other.
// First beat 1 cycle after a bank fills; tready stalls hold the beat, a busy target bank drops samples.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int SAMPLE_W     = DEF_SAMPLE_W,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  output logic [BEAT_W-1:0]   fft_tdata_out,
  output logic                fft_tvalid_out,
  input  logic                fft_tready_in,
  output logic                fft_tlast_out,
  input  logic                result_valid_in,
  input  logic                result_last_in,
  output logic                frame_start_out,
  output logic [15:0]         frame_count_out,
  output logic [15:0]         drop_count_out,
  output logic                overrun_out,
  output logic                timeout_out,
  output logic                busy_out
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST     = AW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

  rd_state_t           state;
  logic [1:0]          bank_full, bank_full_nxt;
  logic                wr_bank, rd_bank;
  logic [AW-1:0]       wr_ptr, rd_idx, rd_addr;
  logic [TW-1:0]       timer;
  logic [SAMPLE_W-1:0] rdata_a, rdata_b, rdata;
  logic [7:0]          rd_real;
  logic                wr_free, wr_acc, wr_drop, wr_fill;
  logic                beat_hs, done, tmo, release_b;

  // A bank released this cycle counts as free so a coincident sample is kept.
  always_comb begin
    done      = (state == WAIT_DONE) && result_valid_in && result_last_in;
    tmo       = (state == WAIT_DONE) && (timer == TMO_LAST);
    release_b = done || tmo;
    wr_free   = !bank_full[wr_bank] || (release_b && (rd_bank == wr_bank));
    wr_acc    = sample_valid_in && enable_in && wr_free;
    wr_drop   = sample_valid_in && enable_in && !wr_free;
    wr_fill   = wr_acc && (wr_ptr == LAST);
    beat_hs   = fft_tvalid_out && fft_tready_in;
    bank_full_nxt = bank_full;
    if (release_b) bank_full_nxt[rd_bank] = 1'b0;
    if (wr_fill)   bank_full_nxt[wr_bank] = 1'b1;
    rd_addr = (beat_hs && (rd_idx != LAST)) ? rd_idx + AW'(1) : rd_idx;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      wr_bank        <= 1'b0;
      bank_full      <= '0;
      drop_count_out <= '0;
      overrun_out    <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (!enable_in) begin
        wr_ptr <= '0;
      end else if (wr_acc) begin
        wr_ptr <= wr_fill ? '0 : wr_ptr + AW'(1);
        if (wr_fill) wr_bank <= !wr_bank;
      end
      if (wr_drop) begin
        overrun_out <= 1'b1;
        if (drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
      end
    end
  end

  frame_bank_ram #(.DEPTH(FRAME_LEN), .WIDTH(SAMPLE_W)) u_bank_a (
    .clk_m   (clk_in),
    .wr_en   (wr_acc && !wr_bank),
    .wr_addr (wr_ptr),
    .wr_dat  (sample_in),
    .rd_addr (rd_addr),
    .rd_dat  (rdata_a)
  );

  frame_bank_ram #(.DEPTH(FRAME_LEN), .WIDTH(SAMPLE_W)) u_bank_b (
    .clk_m   (clk_in),
    .wr_en   (wr_acc && wr_bank),
    .wr_addr (wr_ptr),
    .wr_dat  (sample_in),
    .rd_addr (rd_addr),
    .rd_dat  (rdata_b)
  );

  // The RAM already holds the beat at rd_idx; an idle read address of 0 pre-loads beat 0.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      rd_bank         <= 1'b0;
      rd_idx          <= '0;
      timer           <= '0;
      fft_tvalid_out  <= 1'b0;
      fft_tlast_out   <= 1'b0;
      frame_start_out <= 1'b0;
      frame_count_out <= '0;
      timeout_out     <= 1'b0;
    end else begin
      frame_start_out <= beat_hs && (rd_idx == '0);
      case (state)
        IDLE: begin
          if (|bank_full_nxt) begin
            // Both full only right after a fill: the older one is the new write target.
            rd_bank        <= (&bank_full_nxt) ? (wr_bank ^ wr_fill) : !bank_full_nxt[0];
            rd_idx         <= '0;
            fft_tvalid_out <= 1'b1;
            fft_tlast_out  <= 1'b0;
            state          <= STREAM;
          end
        end
        STREAM: begin
          if (beat_hs) begin
            if (rd_idx == LAST) begin
              state          <= WAIT_DONE;
              fft_tvalid_out <= 1'b0;
              fft_tlast_out  <= 1'b0;
              rd_idx         <= '0;
              timer          <= '0;
            end else begin
              rd_idx        <= rd_idx + AW'(1);
              fft_tlast_out <= ((rd_idx + AW'(1)) == LAST);
            end
          end
        end
        WAIT_DONE: begin
          if (release_b) begin
            state <= IDLE;
            timer <= '0;
            if (done) frame_count_out <= frame_count_out + 16'd1;
            else      timeout_out     <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdata = rd_bank ? rdata_b : rdata_a;

  if (SAMPLE_W >= 8) begin : g_trunc
    assign rd_real = rdata[7:0];
  end else begin : g_sext
    assign rd_real = {{(8 - SAMPLE_W){rdata[SAMPLE_W-1]}}, rdata};
  end

  assign fft_tdata_out = fft_tvalid_out ? {8'h00, rd_real} : '0;
  assign busy_out      = (state != IDLE);

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with a beat scoreboard (FRAME_LEN=8, DONE_TIMEOUT=20).
module tb_fft_frame_scheduler;
  localparam int FL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, sample_valid, tready, res_valid, res_last;
  logic [7:0]  sample;
  logic [15:0] tdata, frame_count, drop_count;
  logic        tvalid, tlast, frame_start, overrun, timeout, busy;

  fft_frame_scheduler #(.FRAME_LEN(FL), .SAMPLE_W(8), .DONE_TIMEOUT(20)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .enable_in       (enable),
    .sample_in       (sample),
    .sample_valid_in (sample_valid),
    .fft_tdata_out   (tdata),
    .fft_tvalid_out  (tvalid),
    .fft_tready_in   (tready),
    .fft_tlast_out   (tlast),
    .result_valid_in (res_valid),
    .result_last_in  (res_last),
    .frame_start_out (frame_start),
    .frame_count_out (frame_count),
    .drop_count_out  (drop_count),
    .overrun_out     (overrun),
    .timeout_out     (timeout),
    .busy_out        (busy)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q [$];
  int          beat_n = 0;
  int          beats_seen = 0;
  int          starts = 0;
  int          b0 = 0;
  logic        stall_prev = 1'b0;
  logic [16:0] stall_dat = '0;
  bit          tr_toggle = 1'b0;
  int          ph = 0;
  logic        pat [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score outputs on the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (stall_prev) begin
      chk("stall_tvalid", 32'(tvalid), 32'(1));
      chk("stall_hold", 32'({tlast, tdata}), 32'(stall_dat));
    end
    stall_prev = tvalid && !tready;
    stall_dat  = {tlast, tdata};
    if (frame_start) starts++;
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 32'(exp_q.size()), 32'(1));
      end else begin
        e = exp_q.pop_front();
        chk("tdata", 32'(tdata), 32'({8'h00, e}));
        chk("tlast", 32'(tlast), 32'(beat_n == FL - 1));
        beat_n = (beat_n + 1) % FL;
        beats_seen++;
      end
    end
    @(posedge clk);
    #1;
    if (tr_toggle) begin
      tready = pat[ph];
      ph = (ph + 1) % 4;
    end
  endtask

  task automatic send(input logic [7:0] v, input bit expect_acc);
    sample       = v;
    sample_valid = 1'b1;
    if (expect_acc) exp_q.push_back(v);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic drain(input int left, input string tag);
    for (int i = 0; i < 80 && (exp_q.size() > left || tvalid); i++) tick();
    chk(tag, 32'(exp_q.size()), 32'(left));
  endtask

  task automatic give_result();
    res_valid = 1'b1;
    res_last  = 1'b1;
    tick();
    res_valid = 1'b0;
    res_last  = 1'b0;
  endtask

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample = '0;
    tready = 1'b1; res_valid = 1'b0; res_last = 1'b0;
    tick();
    tick();
    chk("rst_tvalid", 32'(tvalid), 32'(0));
    chk("rst_tlast", 32'(tlast), 32'(0));
    chk("rst_tdata", 32'(tdata), 32'(0));
    chk("rst_fstart", 32'(frame_start), 32'(0));
    chk("rst_fcount", 32'(frame_count), 32'(0));
    chk("rst_dcount", 32'(drop_count), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // Results outside WAIT_DONE are ignored.
    give_result();
    chk("idle_result_ignored", 32'(frame_count), 32'(0));

    // Plain frame 1..8 with tready held high.
    starts = 0; b0 = beats_seen;
    for (int i = 1; i <= FL; i++) send(8'(i), 1'b1);
    chk("t1_busy", 32'(busy), 32'(1));
    drain(0, "t1_drain");
    chk("t1_beats", 32'(beats_seen - b0), 32'(FL));
    chk("t1_starts", 32'(starts), 32'(1));
    chk("t1_fcount_pre", 32'(frame_count), 32'(0));
    give_result();
    chk("t1_fcount", 32'(frame_count), 32'(1));
    chk("t1_idle", 32'(busy), 32'(0));

    // Same frame with tready pattern 1,0,0,1.
    starts = 0; b0 = beats_seen; ph = 0; tr_toggle = 1'b1;
    for (int i = 1; i <= FL; i++) send(8'(i), 1'b1);
    drain(0, "t2_drain");
    tr_toggle = 1'b0; tready = 1'b1;
    chk("t2_beats", 32'(beats_seen - b0), 32'(FL));
    chk("t2_starts", 32'(starts), 32'(1));
    give_result();
    chk("t2_fcount", 32'(frame_count), 32'(2));

    // 24 back-to-back samples, no results: last 8 dropped, then two timeouts.
    starts = 0;
    for (int i = 1; i <= 3 * FL; i++) send(8'(i), i <= 2 * FL);
    chk("t3_drops", 32'(drop_count), 32'(8));
    chk("t3_overrun", 32'(overrun), 32'(1));
    chk("t3_no_tmo_yet", 32'(timeout), 32'(0));
    drain(0, "t3_drain");
    chk("t3_tmo_a", 32'(timeout), 32'(1));
    chk("t3_busy_b", 32'(busy), 32'(1));
    chk("t3_fcount", 32'(frame_count), 32'(2));
    chk("t3_starts", 32'(starts), 32'(2));
    for (int i = 0; i < 18; i++) tick();
    chk("t3_wait_busy", 32'(busy), 32'(1));
    for (int i = 0; i < 3; i++) tick();
    chk("t3_tmo_idle", 32'(busy), 32'(0));
    chk("t3_fcount_post", 32'(frame_count), 32'(2));

    // Partial fill discarded by one cycle of enable low.
    for (int i = 0; i < 5; i++) send(8'(50 + i), 1'b0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int i = 0; i < FL; i++) send(8'(60 + i), 1'b1);
    drain(0, "t4_drain");
    give_result();
    chk("t4_fcount", 32'(frame_count), 32'(3));
    chk("t4_drops", 32'(drop_count), 32'(8));

    // Release of a bank coincides with a sample aimed at it.
    for (int i = 0; i < FL; i++) send(8'(70 + i), 1'b1);
    drain(0, "t5_drain_b");
    for (int i = 0; i < FL; i++) send(8'(80 + i), 1'b1);
    sample = 8'd90; sample_valid = 1'b1; res_valid = 1'b1; res_last = 1'b1;
    exp_q.push_back(8'd90);
    tick();
    sample_valid = 1'b0; res_valid = 1'b0; res_last = 1'b0;
    chk("t5_no_drop", 32'(drop_count), 32'(8));
    chk("t5_fcount", 32'(frame_count), 32'(4));
    for (int i = 1; i < FL; i++) send(8'(90 + i), 1'b1);
    drain(FL, "t5_drain_a");
    give_result();
    chk("t5_fcount_a", 32'(frame_count), 32'(5));
    drain(0, "t5_drain_b2");
    give_result();
    chk("t5_fcount_b", 32'(frame_count), 32'(6));

    // Reset asserted while beat 4 is on the bus.
    b0 = beats_seen;
    for (int i = 0; i < FL; i++) send(8'(100 + i), 1'b1);
    for (int i = 0; i < 40 && beats_seen < b0 + 4; i++) tick();
    chk("t6_at_beat4", 32'(beats_seen - b0), 32'(4));
    chk("t6_tvalid_pre", 32'(tvalid), 32'(1));
    rst_n = 1'b0;
    tick();
    chk("t6_tvalid", 32'(tvalid), 32'(0));
    chk("t6_tlast", 32'(tlast), 32'(0));
    chk("t6_tdata", 32'(tdata), 32'(0));
    chk("t6_fcount", 32'(frame_count), 32'(0));
    chk("t6_dcount", 32'(drop_count), 32'(0));
    chk("t6_overrun", 32'(overrun), 32'(0));
    chk("t6_timeout", 32'(timeout), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    exp_q.delete();
    beat_n = 0; stall_prev = 1'b0; starts = 0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < FL; i++) send(8'(110 + i), 1'b1);
    drain(0, "t6_drain");
    chk("t6_starts", 32'(starts), 32'(1));
    give_result();
    chk("t6_fcount_post", 32'(frame_count), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
